// File: rtl/rr_arb4_pkg.sv
// Shared types, constants and the round-robin winner search for the rr_arb4 arbiter.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Scans last+1, last+2, ... last+N_REQ (wrapping), so 'last' itself has lowest priority.
  function automatic rr_pick_t rr_next(input logic [N_REQ-1:0] req,
                                       input logic [IDX_W-1:0] last);
    rr_pick_t         pick_v;
    logic [IDX_W-1:0] cand_v;
    pick_v.found = 1'b0;
    pick_v.idx   = last;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_v = last + IDX_W'(i);
      if (!pick_v.found && req[cand_v]) begin
        pick_v.found = 1'b1;
        pick_v.idx   = cand_v;
      end
    end
    return pick_v;
  endfunction

endpackage

// File: rtl/rr_arb4_if.sv
// Request/grant bundle between the requesting units (master) and the arbiter (slave).
interface rr_arb4_if #(
  parameter int CNT_W = 8
);
  import arb_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
`ifdef RR_LOCK_EN
  logic             lock;
`endif
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic [CNT_W-1:0] hold_cnt;

  modport master (
    output en, req,
`ifdef RR_LOCK_EN
    output lock,
`endif
    input  gnt, gnt_idx, gnt_vld, hold_cnt
  );

  modport slave (
    input  en, req,
`ifdef RR_LOCK_EN
    input  lock,
`endif
    output gnt, gnt_idx, gnt_vld, hold_cnt
  );

endinterface

// File: rtl/rr_arb4_dec2to4_en.sv
// 2-to-4 decoder with enable; output is one-hot when enabled, all zero otherwise.
module dec2to4_en
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] y
);

  // One-hot decode gated by enable
  always_comb begin
    y = 4'b0000;
    if (en) begin
      case (idx)
        2'd0:    y = 4'b0001;
        2'd1:    y = 4'b0010;
        2'd2:    y = 4'b0100;
        2'd3:    y = 4'b1000;
        default: y = 4'b0000;
      endcase
    end else begin
      y = 4'b0000;
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with hold-limit preemption and a decoded one-hot grant.
// Optional macro RR_LOCK_EN adds a lock input that suppresses preemption while set.
module rr_arb4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  rr_arb4_if.slave   bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state_r,    state_s;
  logic [IDX_W-1:0] gnt_idx_r,  gnt_idx_s;
  logic             gnt_vld_r,  gnt_vld_s;
  logic [IDX_W-1:0] last_idx_r, last_idx_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;

  logic [N_REQ-1:0] others_s;
  logic             own_req_s;
  logic             lock_s;
  rr_pick_t         pick_any_s;
  rr_pick_t         pick_oth_s;
  logic [N_REQ-1:0] gnt_s;

`ifdef RR_LOCK_EN
  assign lock_s = bus.lock;
`else
  assign lock_s = 1'b0;
`endif

  // Masking the owner keeps a preempted owner from winning its own rotation.
  assign own_req_s  = bus.req[gnt_idx_r];
  assign others_s   = bus.req & ~(N_REQ'(1) << gnt_idx_r);
  assign pick_any_s = rr_next(bus.req, last_idx_r);
  assign pick_oth_s = rr_next(others_s, last_idx_r);

  // Arbitration state register and grant bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      gnt_idx_r  <= 2'd0;
      gnt_vld_r  <= 1'b0;
      last_idx_r <= 2'd3;
      hold_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      gnt_idx_r  <= gnt_idx_s;
      gnt_vld_r  <= gnt_vld_s;
      last_idx_r <= last_idx_s;
      hold_cnt_r <= hold_cnt_s;
    end
  end

  // Next-state: grant, release, preemption, hold counting and disable
  always_comb begin
    state_s    = state_r;
    gnt_idx_s  = gnt_idx_r;
    gnt_vld_s  = gnt_vld_r;
    last_idx_s = last_idx_r;
    hold_cnt_s = hold_cnt_r;
    case (state_r)
      IDLE: begin
        if (!bus.en) begin
          gnt_vld_s  = 1'b0;
          hold_cnt_s = '0;
        end else if (pick_any_s.found) begin
          state_s    = GRANT;
          gnt_idx_s  = pick_any_s.idx;
          gnt_vld_s  = 1'b1;
          last_idx_s = pick_any_s.idx;
          hold_cnt_s = '0;
        end else begin
          gnt_vld_s  = 1'b0;
        end
      end
      GRANT: begin
        if (!bus.en) begin
          state_s    = IDLE;
          gnt_vld_s  = 1'b0;
          hold_cnt_s = '0;
        end else if (!own_req_s) begin
          if (pick_oth_s.found) begin
            gnt_idx_s  = pick_oth_s.idx;
            last_idx_s = pick_oth_s.idx;
            hold_cnt_s = '0;
          end else begin
            state_s    = IDLE;
            gnt_vld_s  = 1'b0;
            hold_cnt_s = '0;
          end
        end else if ((hold_cnt_r == HOLD_LAST) && pick_oth_s.found && !lock_s) begin
          gnt_idx_s  = pick_oth_s.idx;
          last_idx_s = pick_oth_s.idx;
          hold_cnt_s = '0;
        end else if (hold_cnt_r != HOLD_LAST) begin
          hold_cnt_s = hold_cnt_r + CNT_W'(1);
        end else begin
          hold_cnt_s = hold_cnt_r;
        end
      end
      default: begin
        state_s    = IDLE;
        gnt_vld_s  = 1'b0;
        hold_cnt_s = '0;
      end
    endcase
  end

  dec2to4_en u_dec (
    .idx (gnt_idx_r),
    .en  (gnt_vld_r),
    .y   (gnt_s)
  );

  assign bus.gnt      = gnt_s;
  assign bus.gnt_idx  = gnt_idx_r;
  assign bus.gnt_vld  = gnt_vld_r;
  assign bus.hold_cnt = hold_cnt_r;

endmodule
